// File: rtl/io_pkg.sv
// Shared constants for the I/O output bank: write modes, default base word
// and the positions of the address fields.
package io_pkg;

    localparam logic [1:0] IO_MODE_WRITE = 2'b00;
    localparam logic [1:0] IO_MODE_SET   = 2'b01;
    localparam logic [1:0] IO_MODE_CLR   = 2'b10;
    localparam logic [1:0] IO_MODE_TGL   = 2'b11;

    localparam logic [5:0] IO_BASE_WORD = 6'b100000;

    localparam int IO_WIDX_LSB = 2;
    localparam int IO_WIDX_MSB = 7;
    localparam int IO_MODE_LSB = 8;
    localparam int IO_MODE_MSB = 9;

endpackage

// File: rtl/io_port_reg.sv
// One output port register with byte enables, write/set/clear/toggle modes
// and a registered strobe that fires only when the stored value changes.
module io_port_reg
    import io_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    sel_i,
    input  logic [1:0]              mode_i,
    input  logic [DATA_WIDTH-1:0]   mask_i,
    input  logic [DATA_WIDTH/8-1:0] byte_en_i,
    output logic [DATA_WIDTH-1:0]   value_o,
    output logic                    changed_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  changed_q, changed_d;

    // Per-byte next value according to the selected write mode.
    always_comb begin
        value_d = value_q;
        if (sel_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (byte_en_i[b]) begin
                    unique case (mode_i)
                        IO_MODE_WRITE: value_d[b*8 +: 8] = mask_i[b*8 +: 8];
                        IO_MODE_SET:   value_d[b*8 +: 8] = value_q[b*8 +: 8] | mask_i[b*8 +: 8];
                        IO_MODE_CLR:   value_d[b*8 +: 8] = value_q[b*8 +: 8] & ~mask_i[b*8 +: 8];
                        default:       value_d[b*8 +: 8] = value_q[b*8 +: 8] ^ mask_i[b*8 +: 8];
                    endcase
                end
            end
        end
        changed_d = (value_d != value_q);
    end

    // Port value and change strobe registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q   <= RESET_VALUE;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= changed_d;
        end
    end

    assign value_o   = value_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped bank of NUM_PORTS output registers: address decode,
// per-port registers, registered readback and unmapped-access strobe.
module io_output_bank
    import io_pkg::*;
#(
    parameter int                    NUM_PORTS   = 2,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [5:0]            BASE_WORD   = IO_BASE_WORD,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              io_clk,
    input  logic                              reset,
    input  logic [31:0]                       addr,
    input  logic [DATA_WIDTH-1:0]             datain,
    input  logic [DATA_WIDTH/8-1:0]           byte_en,
    input  logic                              write_io_enable,
    input  logic                              read_io_enable,
    output logic [DATA_WIDTH-1:0]             dataout,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   out_port,
    output logic [NUM_PORTS-1:0]              port_changed,
    output logic                              addr_err
);

    if (NUM_PORTS < 1 || NUM_PORTS > 32) begin : g_bad_ports
        $error("io_output_bank: NUM_PORTS must be 1..32");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("io_output_bank: DATA_WIDTH must be a multiple of 8");
    end
    if (int'(BASE_WORD) + NUM_PORTS > 64) begin : g_bad_base
        $error("io_output_bank: BASE_WORD+NUM_PORTS exceeds the 6-bit word index");
    end

    localparam logic [6:0] END_WORD = 7'(BASE_WORD) + 7'(NUM_PORTS);

    logic [5:0] word;
    logic [5:0] idx;
    logic [1:0] mode;
    logic       hit;
    logic       unused_addr_bits;

    assign word = addr[IO_WIDX_MSB:IO_WIDX_LSB];
    assign mode = addr[IO_MODE_MSB:IO_MODE_LSB];
    assign hit  = ({1'b0, word} >= {1'b0, BASE_WORD}) && ({1'b0, word} < END_WORD);
    assign idx  = word - BASE_WORD;
    assign unused_addr_bits = ^{addr[31:10], addr[1:0]};

    logic [DATA_WIDTH-1:0] port_val [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        io_port_reg #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_port (
            .clk_i     (io_clk),
            .reset_i   (reset),
            .sel_i     (write_io_enable && hit && (idx == 6'(k))),
            .mode_i    (mode),
            .mask_i    (datain),
            .byte_en_i (byte_en),
            .value_o   (port_val[k]),
            .changed_o (port_changed[k])
        );
        assign out_port[k*DATA_WIDTH +: DATA_WIDTH] = port_val[k];
    end

    logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
    logic                  addr_err_q, addr_err_d;

    // Readback mux captures the pre-write value; misses raise one error pulse.
    always_comb begin
        dataout_d = dataout_q;
        if (read_io_enable && hit) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (idx == 6'(k)) dataout_d = port_val[k];
            end
        end
        addr_err_d = (write_io_enable || read_io_enable) && !hit;
    end

    // Readback data and error strobe registers.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            dataout_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            dataout_q  <= dataout_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign dataout  = dataout_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_io_output_bank.sv
// Scoreboard bench for io_output_bank: stimulus pushes model expectations,
// a monitor pops and compares one record per clock.
module tb_io_output_bank;

    logic        io_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] datain = '0;
    logic [3:0]  byte_en = '0;
    logic        write_io_enable = 1'b0;
    logic        read_io_enable = 1'b0;
    logic [31:0] dataout;
    logic [63:0] out_port;
    logic [1:0]  port_changed;
    logic        addr_err;

    io_output_bank #(
        .NUM_PORTS  (2),
        .DATA_WIDTH (32),
        .BASE_WORD  (6'h20)
    ) dut (
        .io_clk          (io_clk),
        .reset           (reset),
        .addr            (addr),
        .datain          (datain),
        .byte_en         (byte_en),
        .write_io_enable (write_io_enable),
        .read_io_enable  (read_io_enable),
        .dataout         (dataout),
        .out_port        (out_port),
        .port_changed    (port_changed),
        .addr_err        (addr_err)
    );

    always #5 io_clk = ~io_clk;

    typedef struct packed {
        logic [63:0] ports;
        logic [1:0]  chg;
        logic        err;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    logic [31:0] m_port [2];
    logic [31:0] m_dout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: apply one cycle's request to the abstract port array.
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic we, input logic re);
        exp_t        e;
        int          w;
        int          k;
        logic        h;
        logic [31:0] m;
        logic [31:0] o;
        logic [31:0] nv;
        @(negedge io_clk);
        reset = r; addr = a; datain = d; byte_en = be;
        write_io_enable = we; read_io_enable = re;
        e.chg = 2'b00;
        e.err = 1'b0;
        if (r) begin
            m_port[0] = '0; m_port[1] = '0; m_dout = '0;
        end else begin
            w = int'(a[7:2]);
            h = (w >= 32) && (w < 34);
            k = w - 32;
            e.err = (we || re) && !h;
            if (re && h) m_dout = m_port[k];
            if (we && h) begin
                for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
                o = m_port[k];
                case (a[9:8])
                    2'b00:   nv = (o & ~m) | (d & m);
                    2'b01:   nv = o | (d & m);
                    2'b10:   nv = o & ~(d & m);
                    default: nv = o ^ (d & m);
                endcase
                e.chg[k] = (nv != o);
                m_port[k] = nv;
            end
        end
        e.ports = {m_port[1], m_port[0]};
        e.dout  = m_dout;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per clock edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge io_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_port", 64'(out_port), 64'(e.ports));
                chk("port_changed", 64'(port_changed), 64'(e.chg));
                chk("addr_err", 64'(addr_err), 64'(e.err));
                chk("dataout", 64'(dataout), 64'(e.dout));
            end
        end
    end

    task automatic settle();
        @(posedge io_clk);
        #2;
    endtask

    initial begin
        logic [31:0] ra;
        logic [5:0]  rw;
        m_port[0] = '0; m_port[1] = '0; m_dout = '0;

        drive(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        settle();
        chk("reset_ports", 64'(out_port), 64'h0);
        chk("reset_dout", 64'(dataout), 64'h0);

        drive(1'b0, 32'h080, 32'h12345678, 4'hF, 1'b1, 1'b0);
        settle();
        chk("tp1_port0", 64'(out_port[31:0]), 64'h12345678);
        chk("tp1_chg", 64'(port_changed), 64'h1);

        drive(1'b0, 32'h084, 32'hFFFF0000, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 32'h184, 32'h000000FF, 4'hF, 1'b1, 1'b0);
        settle();
        chk("tp2_set", 64'(out_port[63:32]), 64'hFFFF00FF);
        drive(1'b0, 32'h284, 32'hFF000000, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 32'h384, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        settle();
        chk("tp2_tgl", 64'(out_port[63:32]), 64'hFF00FF00);
        chk("tp2_chg", 64'(port_changed), 64'h2);

        drive(1'b0, 32'h080, 32'hAABBCCDD, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 32'h080, 32'h11223344, 4'h5, 1'b1, 1'b0);
        settle();
        chk("tp3_be", 64'(out_port[31:0]), 64'hAA22CC44);
        drive(1'b0, 32'h080, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0);
        settle();
        chk("tp3_be0_chg", 64'(port_changed), 64'h0);

        drive(1'b0, 32'h080, 32'hAA22CC44, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 32'h080, 32'h0, 4'h0, 1'b0, 1'b1);
        settle();
        chk("tp4_read", 64'(dataout), 64'hAA22CC44);

        drive(1'b0, 32'h088, 32'h55555555, 4'hF, 1'b1, 1'b0);
        settle();
        chk("tp5_werr", 64'(addr_err), 64'h1);
        drive(1'b0, 32'h07C, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h088, 32'h0, 4'hF, 1'b1, 1'b1);
        idle();
        settle();
        chk("tp5_err_clear", 64'(addr_err), 64'h0);

        drive(1'b0, 32'h084, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b1);
        settle();
        chk("tp6_old", 64'(dataout), 64'hFF00FF00);
        chk("tp6_new", 64'(out_port[63:32]), 64'h5A5A5A5A);
        drive(1'b1, 32'h084, 32'h00000001, 4'hF, 1'b1, 1'b1);
        settle();
        chk("tp6_rst_ports", 64'(out_port), 64'h0);
        chk("tp6_rst_dout", 64'(dataout), 64'h0);

        for (int i = 0; i < 1500; i++) begin
            rw = 6'($urandom_range(30, 35));
            ra = $urandom;
            ra[7:2] = rw;
            drive(($urandom_range(0, 49) == 0), ra, $urandom, 4'($urandom),
                  1'($urandom), 1'($urandom));
        end
        idle();

        repeat (3) @(posedge io_clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
